// File: rtl/rr_mux_sel_arbiter.sv
// rr_mux_sel_arbiter: round-robin arbiter that drives the 2-bit select of the
// downstream 4:1 mux. Requester i maps to sel value i. A grant lasts for up to
// BURST accepted beats, or until the granted request drops. One idle bubble
// cycle follows every grant before the next arbitration.
// Optional feature: define GRANT_CNT_EN to add a saturating 16-bit
// grant_total counter output.
module rr_mux_sel_arbiter #(
  parameter int BURST = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic          ready,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic          valid,
  output logic [CW-1:0] beat_cnt
`ifdef GRANT_CNT_EN
  ,
  output logic [15:0]   grant_total
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    last_q, last_d;

  logic [1:0]    win;
  logic          found;
  logic [1:0]    idx;
  logic          beat;
  logic          last_beat;
  logic          start_grant;

  // valid follows the live request of the granted source; never valid in IDLE
  assign valid     = (state_q == GRANT) && req[sel_q];
  assign beat      = valid && ready;
  assign last_beat = (beat_cnt_q == CW'(BURST - 1));

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign beat_cnt = beat_cnt_q;

  // Round-robin search: first set request starting just after the last winner
  always_comb begin
    win   = 2'b00;
    found = 1'b0;
    idx   = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect release in GRANT
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    beat_cnt_d  = beat_cnt_q;
    last_d      = last_q;
    start_grant = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d      = 4'b0000;
        beat_cnt_d = '0;
        if (found) begin
          state_d     = GRANT;
          sel_d       = win;
          gnt_d       = 4'b0001 << win;
          start_grant = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request releases without a beat even if ready is high
        if (!req[sel_q] || (beat && last_beat)) begin
          state_d    = IDLE;
          gnt_d      = 4'b0000;
          beat_cnt_d = '0;
          last_d     = sel_q;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 4'b0000;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset leaves last=3 so requester 0 has first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 2'b00;
      gnt_q      <= 4'b0000;
      beat_cnt_q <= '0;
      last_q     <= 2'd3;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

`ifdef GRANT_CNT_EN
  logic [15:0] grant_total_q, grant_total_d;

  assign grant_total = grant_total_q;

  // Saturating count of IDLE->GRANT transitions
  always_comb begin
    grant_total_d = grant_total_q;
    if (start_grant && (grant_total_q != 16'hFFFF)) begin
      grant_total_d = grant_total_q + 16'd1;
    end
  end

  // Grant counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_total_q <= 16'd0;
    end else begin
      grant_total_q <= grant_total_d;
    end
  end
`else
  logic unused_start_grant;
  assign unused_start_grant = start_grant;
`endif

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Testbench for rr_mux_sel_arbiter (BURST=4). Directed per-cycle vectors push
// hand-computed expected outputs into a scoreboard queue; a monitor pops and
// compares on each falling edge while entries are pending.
module tb_rr_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic [7:0] beat_cnt;
`ifdef GRANT_CNT_EN
  logic [15:0] grant_total;
`endif

  rr_mux_sel_arbiter #(.BURST(4), .CW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ready    (ready),
    .sel      (sel),
    .gnt      (gnt),
    .valid    (valid),
    .beat_cnt (beat_cnt)
`ifdef GRANT_CNT_EN
    ,
    .grant_total (grant_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        valid;
    logic [7:0]  cnt;
    int unsigned id;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned step_id = 0;

  function automatic logic [3:0] oh(input int w);
    logic [3:0] v;
    v = 4'b0000;
    v[w[1:0]] = 1'b1;
    return v;
  endfunction

  // Monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || beat_cnt !== e.cnt) begin
        errors++;
        $display("FAIL cycle%0d: got gnt=%b sel=%b valid=%b cnt=%0d, expected gnt=%b sel=%b valid=%b cnt=%0d",
                 e.id, gnt, sel, valid, beat_cnt, e.gnt, e.sel, e.valid, e.cnt);
      end
    end
  end

  // One cycle: queue the expectation, drive inputs, advance to the next edge
  task automatic cyc(input logic rs, input logic [3:0] r, input logic rd,
                     input logic [3:0] eg, input logic [1:0] es, input logic ev,
                     input logic [7:0] ec);
    exp_t e;
    e.gnt = eg; e.sel = es; e.valid = ev; e.cnt = ec; e.id = step_id;
    step_id++;
    sb_q.push_back(e);
    reset = rs; req = r; ready = rd;
    @(posedge clk); #1;
  endtask

  // Full 4-beat burst to requester w with ready=1, then the bubble cycle
  task automatic burst(input logic [3:0] r, input int w, input logic [3:0] rb);
    for (int k = 0; k < 4; k++) cyc(1'b0, r, 1'b1, oh(w), w[1:0], 1'b1, 8'(k));
    cyc(1'b0, rb, 1'b1, 4'b0000, w[1:0], 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Reset state, then a sole requester 0 re-granted after one bubble
    cyc(1'b0, 4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    burst(4'b0001, 0, 4'b0001);
    burst(4'b0001, 0, 4'b0000);

    // All requesting: rotation 0,1,2,3,0
    do_reset();
    cyc(1'b0, 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    burst(4'b1111, 0, 4'b1111);
    burst(4'b1111, 1, 4'b1111);
    burst(4'b1111, 2, 4'b1111);
    burst(4'b1111, 3, 4'b1111);
    burst(4'b1111, 0, 4'b0000);
`ifdef GRANT_CNT_EN
    checks++;
    if (grant_total !== 16'd5) begin
      errors++;
      $display("FAIL grant_total_5: got %0d expected 5", grant_total);
    end
    @(negedge clk);
    force dut.grant_total_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.grant_total_q;
    cyc(1'b0, 4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0001, 2'b00, 1'b0, 8'd0);
    checks++;
    if (grant_total !== 16'hFFFF) begin
      errors++;
      $display("FAIL grant_total_sat: got %h expected FFFF", grant_total);
    end
    do_reset();
    checks++;
    if (grant_total !== 16'd0) begin
      errors++;
      $display("FAIL grant_total_reset: got %h expected 0000", grant_total);
    end
`endif

    // Alternating ready: grant to 1 spans 8 cycles, then requester 2
    do_reset();
    cyc(1'b0, 4'b0110, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    for (int k = 0; k < 8; k++)
      cyc(1'b0, 4'b0110, logic'(k % 2), 4'b0010, 2'b01, 1'b1, 8'(k / 2));
    cyc(1'b0, 4'b0110, 1'b1, 4'b0000, 2'b01, 1'b0, 8'd0);
    cyc(1'b0, 4'b0110, 1'b1, 4'b0100, 2'b10, 1'b1, 8'd0);

    // Request drop releases without a beat; 2 wins next
    do_reset();
    cyc(1'b0, 4'b0101, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    cyc(1'b0, 4'b0101, 1'b1, 4'b0001, 2'b00, 1'b1, 8'd0);
    cyc(1'b0, 4'b0101, 1'b1, 4'b0001, 2'b00, 1'b1, 8'd1);
    cyc(1'b0, 4'b0100, 1'b1, 4'b0001, 2'b00, 1'b0, 8'd2);
    cyc(1'b0, 4'b0100, 1'b1, 4'b0000, 2'b00, 1'b0, 8'd0);
    cyc(1'b0, 4'b0100, 1'b1, 4'b0100, 2'b10, 1'b1, 8'd0);

    // Reset mid-grant to 3, then requester 0 wins over 3
    do_reset();
    cyc(1'b0, 4'b1000, 1'b0, 4'b0000, 2'b00, 1'b0, 8'd0);
    cyc(1'b0, 4'b1000, 1'b1, 4'b1000, 2'b11, 1'b1, 8'd0);
    cyc(1'b1, 4'b1000, 1'b1, 4'b1000, 2'b11, 1'b1, 8'd1);
    cyc(1'b0, 4'b1001, 1'b0, 4'b0000, 2'b00, 1'b0, 8'd0);
    cyc(1'b0, 4'b1001, 1'b0, 4'b0001, 2'b00, 1'b1, 8'd0);

    req = 4'b0000; ready = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
